// File: rtl/go_board_pkg.sv
// go_board_pkg: shared debouncer state encodings, default timing constants and sizing helper.
package go_board_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int REPEAT_DELAY_DEF    = 12500000;
    localparam int REPEAT_PERIOD_DEF   = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input, cleared by rst.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta_q} <= 2'b00;
        else     {q, meta_q} <= {meta_q, d};
    end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronized pushbutton debouncer emitting a one-cycle pulse per press and a clean level.
// Defining BTN_AUTO_REPEAT_EN adds auto-repeat pulses while the button stays held.
module button_debounce
    import go_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST   = CW'(REPEAT_DELAY - 1);
    // Reloading here makes the next hit of RD_LAST land exactly REPEAT_PERIOD cycles later.
    localparam logic [CW-1:0] RP_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    logic          sync;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          level_q, level_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        case (state_q)
            IDLE:
                if (sync) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            PRESS_CHK:
                if (!sync) state_d = IDLE;
                else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else cnt_d = cnt_q + CW'(1);
            HELD:
                if (!sync) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (cnt_q == RD_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = RP_RELOAD;
                end else cnt_d = cnt_q + CW'(1);
`endif
            REL_CHK:
                if (sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else cnt_d = cnt_q + CW'(1);
            default: state_d = IDLE;
        endcase
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed table-driven bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic pulse, level;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses = 0;
    int   pe[$];
    int   exp_pe[$];

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .pulse  (pulse),
        .level  (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        int   cycles;
        int   exp_pulses;
        logic exp_level;
        int   exp_total;
    } seg_t;

    seg_t segs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pulse === 1'b1) pulses++;
    endtask

    task automatic edges_to_pulse(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pulse === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int base;
        int n;
        segs[0]  = '{1'b0,  5, 0, 1'b0, 0};
        segs[1]  = '{1'b1,  3, 0, 1'b0, 0};
        segs[2]  = '{1'b0,  5, 0, 1'b0, 0};
        segs[3]  = '{1'b1,  2, 0, 1'b0, 0};
        segs[4]  = '{1'b0,  2, 0, 1'b0, 0};
        segs[5]  = '{1'b1,  2, 0, 1'b0, 0};
        segs[6]  = '{1'b0,  2, 0, 1'b0, 0};
        segs[7]  = '{1'b1, 10, 1, 1'b1, 1};
        segs[8]  = '{1'b0,  3, 0, 1'b1, 1};
        segs[9]  = '{1'b1,  6, 0, 1'b1, 1};
        segs[10] = '{1'b0, 10, 0, 1'b0, 1};
        segs[11] = '{1'b1, 10, 1, 1'b1, 2};
        segs[12] = '{1'b0, 10, 0, 1'b0, 2};
`ifdef BTN_AUTO_REPEAT_EN
        exp_pe = '{7, 17, 20, 23, 26, 29};
`else
        exp_pe = '{7};
`endif
        #12;
        check("reset pulse", pulse, 0);
        check("reset level", level, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            btn_in = segs[i].btn;
            base = pulses;
            repeat (segs[i].cycles) tick();
            check($sformatf("seg%0d pulses", i), pulses - base, segs[i].exp_pulses);
            check($sformatf("seg%0d level", i), level, segs[i].exp_level);
            check($sformatf("seg%0d counter", i), pulses, segs[i].exp_total);
        end

        btn_in = 1'b1;
        pe.delete();
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (pulse === 1'b1) pe.push_back(k);
            if (k <= 8) begin
                check($sformatf("press e%0d pulse", k), pulse, (k == 7));
                check($sformatf("press e%0d level", k), level, (k >= 7));
            end
        end
        check("hold pulse count", pe.size(), exp_pe.size());
        for (int i = 0; i < exp_pe.size() && i < pe.size(); i++)
            check($sformatf("hold pulse %0d edge", i), pe[i], exp_pe[i]);

        btn_in = 1'b0;
        base = pulses;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6 || k == 7) check($sformatf("release e%0d level", k), level, (k < 7));
        end
        check("release pulses", pulses - base, 0);

        btn_in = 1'b1;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("rst mid-press pulse", pulse, 0);
        check("rst mid-press level", level, 0);
        rst = 1'b0;
        edges_to_pulse(n);
        check("rst press latency", n, 7);
        check("held level after rst", level, 1);

        tick();
        #2 rst = 1'b1;
        #1;
        check("rst held level", level, 0);
        check("rst held pulse", pulse, 0);
        rst = 1'b0;
        edges_to_pulse(n);
        check("rst held latency", n, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
